lcd1602_responder: RTL and testbench

HD44780-compatible responder for the LCD1602 bus: the display-side end of the 8-bit parallel interface our LCD controllers drive. It samples `lcd_e` falling edges on the system clock, decodes instructions and data, keeps a 128-byte DDRAM image plus display/entry state, models the busy flag, and answers bus reads. It sits in simulation benches and on-chip debug builds, where the DDRAM image is read back through a side port to check what the controller drew.

---
 rtl/lcd1602_responder.sv | 212 +++++++++++++++++++++
 tb/tb_lcd1602_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd1602_responder.sv
// lcd1602_responder: HD44780-style display-side responder for the LCD1602 8-bit parallel bus.
// Build option LCD_RESP_STRICT_BUSY_EN: drop (instead of execute) write transfers arriving while busy.
module lcd1602_responder #(
  parameter int unsigned BUSY_CYCLES       = 2000,
  parameter int unsigned CLEAR_BUSY_CYCLES = 80000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [7:0] lcd_data_i,
  output logic [7:0] lcd_data_o,
  output logic       lcd_data_oe,
  output logic       busy,
  output logic [6:0] ddram_addr,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       mode_8bit,
  output logic       two_line,
  output logic       entry_inc,
  output logic       entry_shift,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       cmd_valid,
  output logic       err,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLEAR, S_BUSY} state_t;

  // Busy time is counted from the EXEC cycle; EXEC and the 128 CLEAR cycles are part of it.
  localparam logic [31:0] BUSY_LOAD  = 32'(BUSY_CYCLES - 2);
  localparam logic [31:0] HOME_LOAD  = 32'(CLEAR_BUSY_CYCLES - 2);
  localparam logic [31:0] CLEAR_LOAD = 32'(CLEAR_BUSY_CYCLES - 130);

  state_t      state;
  logic        e_s1, e_s2, e_prev, rs_s1, rs_s2, rw_s1, rw_s2;
  logic [7:0]  data_s1, data_s2;
  logic        fall_q, cap_rs, cap_rw, rd_pend;
  logic [7:0]  cap_data;
  logic        cmd_rs;
  logic [7:0]  cmd_data;
  logic [31:0] busy_cnt;
  logic [6:0]  clr_addr;
  logic [7:0]  ddram [128];
  logic        mem_we;
  logic [6:0]  mem_waddr;
  logic [7:0]  mem_wdata;
  logic        wr_fall, rd_fall;
`ifndef LCD_RESP_STRICT_BUSY_EN
  logic        pend;
`endif

  assign fsm_state = state;
  assign wr_fall   = fall_q & ~cap_rw;
  assign rd_fall   = fall_q & cap_rw;

  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc, input logic two);
    logic [6:0] r;
    r = inc ? a + 7'd1 : a - 7'd1;
    if (two) begin
      if (inc && a == 7'h27)       r = 7'h40;
      else if (inc && a == 7'h67)  r = 7'h00;
      else if (!inc && a == 7'h00) r = 7'h67;
      else if (!inc && a == 7'h40) r = 7'h27;
    end else begin
      if (inc && a == 7'h4F)       r = 7'h00;
      else if (!inc && a == 7'h00) r = 7'h4F;
    end
    return r;
  endfunction

  function automatic logic addr_valid(input logic [6:0] a, input logic two);
    return two ? ((a <= 7'h27) || (a >= 7'h40 && a <= 7'h67)) : (a <= 7'h4F);
  endfunction

  // Bus synchronizer; the falling-edge capture adds one register stage ahead of the FSM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      e_s1 <= 1'b0; e_s2 <= 1'b0; e_prev <= 1'b0;
      rs_s1 <= 1'b0; rs_s2 <= 1'b0; rw_s1 <= 1'b0; rw_s2 <= 1'b0;
      data_s1 <= 8'h00; data_s2 <= 8'h00;
      fall_q <= 1'b0; cap_rs <= 1'b0; cap_rw <= 1'b0; cap_data <= 8'h00;
    end else begin
      e_s1 <= lcd_e;      e_s2 <= e_s1;   e_prev <= e_s2;
      rs_s1 <= lcd_rs;    rs_s2 <= rs_s1;
      rw_s1 <= lcd_rw;    rw_s2 <= rw_s1;
      data_s1 <= lcd_data_i; data_s2 <= data_s1;
      fall_q <= e_prev & ~e_s2;
      if (e_prev && !e_s2) begin
        cap_rs   <= rs_s2;
        cap_rw   <= rw_s2;
        cap_data <= data_s2;
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ddram_addr;
    mem_wdata = cmd_data;
    if (reset) begin
      if (state == S_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr;
        mem_wdata = 8'h20;
      end else if (state == S_EXEC && cmd_rs && addr_valid(ddram_addr, two_line)) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) ddram[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data     <= 8'h00;
      lcd_data_o  <= 8'h00;
      lcd_data_oe <= 1'b0;
    end else begin
      rd_data     <= ddram[rd_addr];
      lcd_data_oe <= e_s2 & rw_s2;
      if (e_s2 && rw_s2) lcd_data_o <= rs_s2 ? ddram[ddram_addr] : {busy, ddram_addr};
      else               lcd_data_o <= 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE; ddram_addr <= 7'h00; busy <= 1'b0; busy_cnt <= 32'd0;
      clr_addr <= 7'h00; rd_pend <= 1'b0; cmd_rs <= 1'b0; cmd_data <= 8'h00;
      display_on <= 1'b0; cursor_on <= 1'b0; blink_on <= 1'b0;
      mode_8bit <= 1'b1; two_line <= 1'b0; entry_inc <= 1'b1; entry_shift <= 1'b0;
      cmd_valid <= 1'b0; err <= 1'b0;
`ifndef LCD_RESP_STRICT_BUSY_EN
      pend <= 1'b0;
`endif
    end else begin
      cmd_valid <= 1'b0;
      err       <= 1'b0;
      rd_pend   <= rd_fall;
      // Reads bypass the FSM: never gated by busy and never add busy time.
      if (rd_pend) begin
        cmd_valid <= 1'b1;
        if (cap_rs) ddram_addr <= step_addr(ddram_addr, entry_inc, two_line);
      end
      if (wr_fall && state != S_IDLE) err <= 1'b1;
      case (state)
        S_IDLE: if (wr_fall) begin
          state <= S_EXEC; busy <= 1'b1; cmd_rs <= cap_rs; cmd_data <= cap_data;
        end
        S_EXEC: begin
          cmd_valid <= 1'b1;
          state     <= S_BUSY;
          busy_cnt  <= BUSY_LOAD;
          if (cmd_rs) ddram_addr <= step_addr(ddram_addr, entry_inc, two_line);
          else begin
            casez (cmd_data)
              8'b1???????: ddram_addr <= cmd_data[6:0];
              8'b01??????: err <= 1'b1;
              8'b001?????: begin mode_8bit <= cmd_data[4]; two_line <= cmd_data[3]; end
              8'b0001????: if (cmd_data[3]) err <= 1'b1;
                           else ddram_addr <= step_addr(ddram_addr, cmd_data[2], two_line);
              8'b00001???: begin
                display_on <= cmd_data[2]; cursor_on <= cmd_data[1]; blink_on <= cmd_data[0];
              end
              8'b000001??: begin entry_inc <= cmd_data[1]; entry_shift <= cmd_data[0]; end
              8'b0000001?: begin ddram_addr <= 7'h00; busy_cnt <= HOME_LOAD; end
              8'b00000001: begin state <= S_CLEAR; clr_addr <= 7'h00; end
              default:     err <= 1'b1;
            endcase
          end
        end
        S_CLEAR: begin
          clr_addr <= clr_addr + 7'd1;
`ifndef LCD_RESP_STRICT_BUSY_EN
          // A write during the fill is held and executed as soon as the fill finishes.
          if (wr_fall) begin pend <= 1'b1; cmd_rs <= cap_rs; cmd_data <= cap_data; end
`endif
          if (clr_addr == 7'h7F) begin
            ddram_addr <= 7'h00;
            entry_inc  <= 1'b1;
            state      <= S_BUSY;
            busy_cnt   <= CLEAR_LOAD;
          end
        end
        S_BUSY: begin
`ifdef LCD_RESP_STRICT_BUSY_EN
          if (busy_cnt == 32'd0) begin state <= S_IDLE; busy <= 1'b0; end
          else busy_cnt <= busy_cnt - 32'd1;
`else
          if (wr_fall || pend) begin
            state <= S_EXEC;
            pend  <= 1'b0;
            if (wr_fall) begin cmd_rs <= cap_rs; cmd_data <= cap_data; end
          end else if (busy_cnt == 32'd0) begin
            state <= S_IDLE; busy <= 1'b0;
          end else begin
            busy_cnt <= busy_cnt - 32'd1;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd1602_responder.sv
// Directed bench for lcd1602_responder: expected per-transfer state is queued at issue and
// compared by a monitor on every cmd_valid pulse; DDRAM and bus reads are checked directly.
`timescale 1ns/1ps
module tb_lcd1602_responder;
  localparam int unsigned BUSY_CYC = 20;
  localparam int unsigned CLR_CYC  = 200;
  localparam int W = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_e = 1'b0;
  logic [7:0] lcd_data_i = 8'h00;
  logic [7:0] lcd_data_o;
  logic       lcd_data_oe, busy;
  logic [6:0] ddram_addr;
  logic       display_on, cursor_on, blink_on, mode_8bit, two_line, entry_inc, entry_shift;
  logic [6:0] rd_addr = 7'h00;
  logic [7:0] rd_data;
  logic       cmd_valid, err;
  logic [1:0] fsm_state;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int err_count = 0;

  always #5 clk = ~clk;

  lcd1602_responder #(.BUSY_CYCLES(BUSY_CYC), .CLEAR_BUSY_CYCLES(CLR_CYC)) dut (
    .clk(clk), .reset(reset), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_data_i(lcd_data_i), .lcd_data_o(lcd_data_o), .lcd_data_oe(lcd_data_oe),
    .busy(busy), .ddram_addr(ddram_addr), .display_on(display_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .mode_8bit(mode_8bit), .two_line(two_line), .entry_inc(entry_inc),
    .entry_shift(entry_shift), .rd_addr(rd_addr), .rd_data(rd_data),
    .cmd_valid(cmd_valid), .err(err), .fsm_state(fsm_state)
  );

  // flags = {D, C, B, DL, N, I/D, S}
  function automatic logic [W-1:0] mk_exp(input logic e, input logic [6:0] a, input logic [6:0] flags);
    return {e, a, flags};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] act;
    if (err) err_count++;
    if (reset && cmd_valid) begin
      act = {err, ddram_addr, display_on, cursor_on, blink_on, mode_8bit, two_line, entry_inc, entry_shift};
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL cmd_unexpected: got state 0x%0h expected no transfer", act);
      end else begin
        check("cmd_state", act, exp_q.pop_front());
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic xfer(input logic rs, input logic rw, input logic [7:0] d);
    @(posedge clk); #1;
    lcd_rs = rs; lcd_rw = rw; lcd_data_i = d; lcd_e = 1'b1;
    repeat (4) @(posedge clk); #1;
    lcd_e = 1'b0;
    repeat (4) @(posedge clk); #1;
    lcd_rw = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin @(negedge clk); n++; end
    if (busy) begin
      n_checks++;
      $display("FAIL busy_timeout: busy=1 after %0d cycles expected 0", n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wr(input logic rs, input logic [7:0] d, input logic [W-1:0] e, input logic do_wait);
    exp_q.push_back(e);
    xfer(rs, 1'b0, d);
    if (do_wait) wait_idle();
  endtask

  task automatic check_mem(input logic [6:0] a, input logic [7:0] e, input string name);
    @(posedge clk); #1;
    rd_addr = a;
    @(posedge clk); #1;
    check(name, rd_data, e);
  endtask

  // Bus read: checks the data driven while E is high, then queues the state after the fall.
  task automatic bus_read(input logic rs, input logic [7:0] e_data, input logic [W-1:0] e_state,
                          input string name);
    @(posedge clk); #1;
    lcd_rs = rs; lcd_rw = 1'b1; lcd_e = 1'b1;
    exp_q.push_back(e_state);
    repeat (4) @(posedge clk); #1;
    check({name, "_oe"}, lcd_data_oe, 1);
    check({name, "_data"}, lcd_data_o, e_data);
    lcd_e = 1'b0;
    repeat (4) @(posedge clk); #1;
    check({name, "_oe_low"}, lcd_data_oe, 0);
    lcd_rw = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int err_before;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_addr", ddram_addr, 0);
    check("rst_flags", {display_on, cursor_on, blink_on, mode_8bit, two_line, entry_inc, entry_shift},
          7'b0001010);
    check("rst_oe", lcd_data_oe, 0);
    check("rst_data_o", lcd_data_o, 0);
    check("rst_cmd_err", {cmd_valid, err}, 0);
    check("rst_rd_data", rd_data, 0);

    bus_read(1'b0, 8'h00, mk_exp(0, 7'h00, 7'b0001010), "ir_read");

    wr(0, 8'h38, mk_exp(0, 7'h00, 7'b0001110), 1);
    wr(0, 8'h06, mk_exp(0, 7'h00, 7'b0001110), 1);
    wr(0, 8'h0C, mk_exp(0, 7'h00, 7'b1001110), 1);
    wr(0, 8'h01, mk_exp(0, 7'h00, 7'b1001110), 1);
    check("clear_addr", ddram_addr, 0);
    check("clear_entry_inc", entry_inc, 1);
    check_mem(7'h00, 8'h20, "clear_mem_00");
    check_mem(7'h7F, 8'h20, "clear_mem_7f");

    // Line-1 end wraps to line-2 start
    wr(0, 8'hA7, mk_exp(0, 7'h27, 7'b1001110), 1);
    wr(1, 8'h41, mk_exp(0, 7'h40, 7'b1001110), 1);
    wr(1, 8'h42, mk_exp(0, 7'h41, 7'b1001110), 1);
    check("ab_addr", ddram_addr, 7'h41);
    check_mem(7'h27, 8'h41, "mem_27_A");
    check_mem(7'h40, 8'h42, "mem_40_B");

    // Decrementing from line-2 start wraps to line-1 end
    wr(0, 8'hC0, mk_exp(0, 7'h40, 7'b1001110), 1);
    wr(0, 8'h04, mk_exp(0, 7'h40, 7'b1001100), 1);
    wr(1, 8'h58, mk_exp(0, 7'h27, 7'b1001100), 1);
    check_mem(7'h40, 8'h58, "mem_40_X");

    wr(0, 8'h40, mk_exp(1, 7'h27, 7'b1001100), 1);
    wr(0, 8'h18, mk_exp(1, 7'h27, 7'b1001100), 1);

    bus_read(1'b1, 8'h41, mk_exp(0, 7'h26, 7'b1001100), "data_read");
    wr(0, 8'h14, mk_exp(0, 7'h27, 7'b1001100), 0);
    bus_read(1'b0, 8'hA7, mk_exp(0, 7'h27, 7'b1001100), "ir_read_busy");
    wait_idle();
    wr(0, 8'h14, mk_exp(0, 7'h40, 7'b1001100), 1);
    wr(0, 8'h10, mk_exp(0, 7'h27, 7'b1001100), 1);
    wr(0, 8'h06, mk_exp(0, 7'h27, 7'b1001110), 1);

    wr(0, 8'hE7, mk_exp(0, 7'h67, 7'b1001110), 1);
    wr(1, 8'h51, mk_exp(0, 7'h00, 7'b1001110), 1);
    check_mem(7'h67, 8'h51, "mem_67_Q");

    // Out-of-range address: write dropped, address still steps
    wr(0, 8'hB0, mk_exp(0, 7'h30, 7'b1001110), 1);
    wr(1, 8'h52, mk_exp(0, 7'h31, 7'b1001110), 1);
    check_mem(7'h30, 8'h20, "mem_30_dropped");

    wr(0, 8'h02, mk_exp(0, 7'h00, 7'b1001110), 1);

    wr(0, 8'h30, mk_exp(0, 7'h00, 7'b1001010), 1);
    wr(0, 8'hCF, mk_exp(0, 7'h4F, 7'b1001010), 1);
    wr(1, 8'h4D, mk_exp(0, 7'h00, 7'b1001010), 1);
    check_mem(7'h4F, 8'h4D, "mem_4f_M");
    wr(0, 8'h10, mk_exp(0, 7'h4F, 7'b1001010), 1);
    wr(0, 8'h80, mk_exp(0, 7'h00, 7'b1001010), 1);

    // Second write lands while the first is still busy
    wr(1, 8'h59, mk_exp(0, 7'h01, 7'b1001010), 0);
    repeat (4) @(posedge clk);
    err_before = err_count;
`ifdef LCD_RESP_STRICT_BUSY_EN
    xfer(1'b0 ^ 1'b1, 1'b0, 8'h5A);
    repeat (15) @(posedge clk); #1;
    check("busy_after_drop", busy, 0);
`else
    wr(1, 8'h5A, mk_exp(0, 7'h02, 7'b1001010), 0);
    repeat (15) @(posedge clk); #1;
    check("busy_extended", busy, 1);
`endif
    wait_idle();
    check("busy_write_err", err_count - err_before, 1);
    check_mem(7'h00, 8'h59, "mem_00_Y");
`ifdef LCD_RESP_STRICT_BUSY_EN
    check_mem(7'h01, 8'h20, "mem_01_unchanged");
    check("busy_write_addr", ddram_addr, 7'h01);
`else
    check_mem(7'h01, 8'h5A, "mem_01_Z");
    check("busy_write_addr", ddram_addr, 7'h02);
`endif

    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
